alu_mc: RTL and testbench

ALU_MC -- requirements
Module: alu_mc

---
 rtl/alu_mc.sv | 173 +++++++++++++++++
 tb/tb_alu_mc.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle arithmetic/logic ops plus iterative shift-add MUL
// and restoring DIV, with a valid/ready command handshake and a held result.
module alu_mc #(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [3:0]         op,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] result,
    output logic               carry,
    output logic               zero,
    output logic               dbz
);
    localparam int unsigned W2 = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH + 1);

    localparam logic [3:0] OP_ADD = 4'h0, OP_SUB = 4'h1, OP_MUL = 4'h2, OP_DIV = 4'h3;
    localparam logic [3:0] OP_SHL = 4'h4, OP_SHR = 4'h5, OP_ROL = 4'h6, OP_ROR = 4'h7;
    localparam logic [3:0] OP_AND = 4'h8, OP_OR = 4'h9, OP_XOR = 4'hA, OP_NOR = 4'hB;
    localparam logic [3:0] OP_NAND = 4'hC, OP_XNOR = 4'hD, OP_GT = 4'hE, OP_EQ = 4'hF;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_is_div;
    logic [CW-1:0]    r_cnt;
    logic [W2-1:0]    r_result;
    logic             r_carry;
    logic             r_zero;
    logic             r_dbz;

    logic             w_accept;
    logic             w_multi;
    logic             w_last;
    logic [WIDTH:0]   w_add;
    logic [WIDTH:0]   w_sub;
    logic [W2-1:0]    w_sc_result;
    logic             w_sc_carry;
    logic             w_sc_dbz;
    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH:0]   w_div_shift;
    logic [WIDTH:0]   w_div_trial;
    logic [WIDTH-1:0] w_hi_nxt;
    logic [WIDTH-1:0] w_lo_nxt;
    logic [W2-1:0]    w_calc_result;

    assign w_accept = in_valid && in_ready;
    assign w_multi  = (op == OP_MUL) || ((op == OP_DIV) && (b != '0));
    assign w_last   = (r_state == S_CALC) && (r_cnt == CW'(1));
    assign w_add    = {1'b0, a} + {1'b0, b};
    assign w_sub    = {1'b0, a} - {1'b0, b};

    // Single-cycle results; DIV here only covers the divide-by-zero case
    always_comb begin
        w_sc_result = '0;
        w_sc_carry  = 1'b0;
        w_sc_dbz    = 1'b0;
        case (op)
            OP_ADD:  begin w_sc_result = {{(WIDTH-1){1'b0}}, w_add}; w_sc_carry = w_add[WIDTH]; end
            OP_SUB:  begin w_sc_result = {{(WIDTH-1){1'b0}}, w_sub}; w_sc_carry = w_sub[WIDTH]; end
            OP_DIV:  begin w_sc_result = {a, {WIDTH{1'b1}}}; w_sc_dbz = 1'b1; end
            OP_SHL:  begin w_sc_result = {{WIDTH{1'b0}}, a[WIDTH-2:0], 1'b0}; w_sc_carry = a[WIDTH-1]; end
            OP_SHR:  begin w_sc_result = {{WIDTH{1'b0}}, 1'b0, a[WIDTH-1:1]}; w_sc_carry = a[0]; end
            OP_ROL:  begin w_sc_result = {{WIDTH{1'b0}}, a[WIDTH-2:0], a[WIDTH-1]}; w_sc_carry = a[WIDTH-1]; end
            OP_ROR:  begin w_sc_result = {{WIDTH{1'b0}}, a[0], a[WIDTH-1:1]}; w_sc_carry = a[0]; end
            OP_AND:  w_sc_result = {{WIDTH{1'b0}}, a & b};
            OP_OR:   w_sc_result = {{WIDTH{1'b0}}, a | b};
            OP_XOR:  w_sc_result = {{WIDTH{1'b0}}, a ^ b};
            OP_NOR:  w_sc_result = {{WIDTH{1'b0}}, ~(a | b)};
            OP_NAND: w_sc_result = {{WIDTH{1'b0}}, ~(a & b)};
            OP_XNOR: w_sc_result = {{WIDTH{1'b0}}, ~(a ^ b)};
            OP_GT:   w_sc_result = {{(W2-1){1'b0}}, (a > b)};
            OP_EQ:   w_sc_result = {{(W2-1){1'b0}}, (a == b)};
            default: w_sc_result = '0;
        endcase
    end

    // One iteration: MUL shifts {hi,lo} right after adding B; DIV shifts left and restores
    always_comb begin
        w_mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : {(WIDTH+1){1'b0}});
        w_div_shift = {r_hi, r_lo[WIDTH-1]};
        w_div_trial = w_div_shift - {1'b0, r_b};
        if (r_is_div) begin
            w_hi_nxt = w_div_trial[WIDTH] ? w_div_shift[WIDTH-1:0] : w_div_trial[WIDTH-1:0];
            w_lo_nxt = {r_lo[WIDTH-2:0], ~w_div_trial[WIDTH]};
        end else begin
            w_hi_nxt = w_mul_sum[WIDTH:1];
            w_lo_nxt = {w_mul_sum[0], r_lo[WIDTH-1:1]};
        end
        w_calc_result = {w_hi_nxt, w_lo_nxt};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = w_multi ? S_CALC : S_DONE;
            S_CALC:  if (w_last) w_state_nxt = S_DONE;
            S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            S_IDLE:  in_ready  = 1'b1;
            S_DONE:  out_valid = 1'b1;
            default: ;
        endcase
    end

    // Operand capture, iteration registers and the held result/flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_b      <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_is_div <= 1'b0;
            r_cnt    <= '0;
            r_result <= '0;
            r_carry  <= 1'b0;
            r_zero   <= 1'b0;
            r_dbz    <= 1'b0;
        end else if (w_accept) begin
            r_b      <= b;
            r_hi     <= '0;
            r_lo     <= a;
            r_is_div <= (op == OP_DIV);
            r_cnt    <= CW'(WIDTH);
            if (!w_multi) begin
                r_result <= w_sc_result;
                r_carry  <= w_sc_carry;
                r_zero   <= (w_sc_result == '0);
                r_dbz    <= w_sc_dbz;
            end
        end else if (r_state == S_CALC) begin
            r_hi  <= w_hi_nxt;
            r_lo  <= w_lo_nxt;
            r_cnt <= r_cnt - CW'(1);
            if (w_last) begin
                r_result <= w_calc_result;
                r_carry  <= 1'b0;
                r_zero   <= (w_calc_result == '0);
                r_dbz    <= 1'b0;
            end
        end
    end

    assign result = r_result;
    assign carry  = r_carry;
    assign zero   = r_zero;
    assign dbz    = r_dbz;

endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc (WIDTH=8): directed cases plus random commands checked against
// an arithmetic reference model, including backpressure and mid-operation reset.
module tb_alu_mc;
    localparam int unsigned W = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [3:0]     op;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] result;
    logic           carry;
    logic           zero;
    logic           dbz;

    int n_checks = 0;
    int n_errors = 0;

    alu_mc #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .carry(carry), .zero(zero), .dbz(dbz)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on the operands
    function automatic void model(input int unsigned ma, input int unsigned mb, input int unsigned mop,
                                  output logic [15:0] r, output logic c, output logic d, output int lat);
        int unsigned v;
        v = 0; c = 1'b0; d = 1'b0; lat = 1;
        case (mop)
            0:  begin v = ma + mb; c = (v > 255); end
            1:  begin c = (ma < mb); v = ((ma - mb) & 255) + (c ? 256 : 0); end
            2:  begin v = ma * mb; lat = 9; end
            3:  if (mb == 0) begin v = ma * 256 + 255; d = 1'b1; end
                else begin v = (ma % mb) * 256 + ma / mb; lat = 9; end
            4:  begin v = (ma * 2) & 255; c = (ma >= 128); end
            5:  begin v = ma / 2; c = (ma % 2 == 1); end
            6:  begin v = ((ma * 2) & 255) + ma / 128; c = (ma >= 128); end
            7:  begin v = ma / 2 + (ma % 2) * 128; c = (ma % 2 == 1); end
            8:  v = ma & mb;
            9:  v = ma | mb;
            10: v = ma ^ mb;
            11: v = ~(ma | mb) & 255;
            12: v = ~(ma & mb) & 255;
            13: v = ~(ma ^ mb) & 255;
            14: v = (ma > mb) ? 1 : 0;
            default: v = (ma == mb) ? 1 : 0;
        endcase
        r = v[15:0];
    endfunction

    // Issue one command, keep in_valid noise high while busy, stall, then handshake
    task automatic run_cmd(input logic [7:0] ta, input logic [7:0] tbv, input logic [3:0] top,
                           input int stall, input string tag, output logic [15:0] obs_res);
        logic [15:0] e_res;
        logic        e_c;
        logic        e_d;
        int          e_lat;
        int          lat;
        int          rdy_hi;
        model(ta, tbv, top, e_res, e_c, e_d, e_lat);
        @(negedge clk);
        chk($sformatf("%s.in_ready_idle", tag), in_ready, 1);
        in_valid = 1'b1; a = ta; b = tbv; op = top;
        @(posedge clk); #1;
        a = 8'($urandom); b = 8'($urandom); op = 4'($urandom);
        lat = 1; rdy_hi = 0;
        while (!out_valid && lat < 40) begin
            if (in_ready) rdy_hi++;
            @(posedge clk); #1;
            lat++;
        end
        chk($sformatf("%s.latency", tag), lat, e_lat);
        chk($sformatf("%s.busy_ready", tag), rdy_hi, 0);
        chk($sformatf("%s.result", tag), result, e_res);
        chk($sformatf("%s.carry", tag), carry, e_c);
        chk($sformatf("%s.zero", tag), zero, (e_res == 16'h0));
        chk($sformatf("%s.dbz", tag), dbz, e_d);
        obs_res = result;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            a = 8'($urandom); b = 8'($urandom);
            chk($sformatf("%s.hold_valid", tag), out_valid, 1);
            chk($sformatf("%s.hold_ready", tag), in_ready, 0);
            chk($sformatf("%s.hold_result", tag), result, e_res);
            chk($sformatf("%s.hold_carry", tag), carry, e_c);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        chk($sformatf("%s.after_valid", tag), out_valid, 0);
        chk($sformatf("%s.after_ready", tag), in_ready, 1);
    endtask

    initial begin
        logic [15:0] res;
        int          seen;
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; op = '0; out_ready = 1'b0;
        #1;
        chk("reset.result", result, 0);
        chk("reset.out_valid", out_valid, 0);
        chk("reset.flags", {carry, zero, dbz}, 0);
        chk("reset.in_ready", in_ready, 1);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run_cmd(8'd200, 8'd100, 4'h0, 0, "add", res);
        chk("add.spec", res, 16'h012C);
        run_cmd(8'd255, 8'd255, 4'h2, 1, "mul", res);
        chk("mul.spec", res, 16'hFE01);
        run_cmd(8'd200, 8'd7, 4'h3, 0, "div", res);
        chk("div.spec", res, 16'h041C);
        run_cmd(8'd5, 8'd0, 4'h3, 0, "div0", res);
        chk("div0.spec", res, 16'h05FF);
        run_cmd(8'd3, 8'd5, 4'h1, 0, "sub", res);
        chk("sub.spec", res, 16'h01FE);
        run_cmd(8'h5A, 8'h5A, 4'hF, 0, "eq", res);
        chk("eq.spec", res, 16'h0001);
        run_cmd(8'h3C, 8'h3C, 4'hA, 0, "xor", res);
        run_cmd(8'd0, 8'd77, 4'h2, 0, "mul0", res);
        run_cmd(8'd3, 8'd200, 4'h3, 0, "div_small", res);
        run_cmd(8'h81, 8'h00, 4'h6, 5, "rol_bp", res);
        chk("rol_bp.spec", res, 16'h0003);

        for (int i = 0; i < 40; i++) begin
            logic [7:0] ra;
            logic [7:0] rb;
            ra = 8'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            run_cmd(ra, rb, 4'($urandom_range(0, 15)), $urandom_range(0, 2), $sformatf("rnd%0d", i), res);
        end

        // Reset four cycles into a MUL must abort it with no result
        @(negedge clk);
        in_valid = 1'b1; a = 8'd255; b = 8'd255; op = 4'h2;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort.result", result, 0);
        chk("abort.out_valid", out_valid, 0);
        chk("abort.flags", {carry, zero, dbz}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort.in_ready", in_ready, 1);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk("abort.no_pulse", seen, 0);
        run_cmd(8'd1, 8'd1, 4'h0, 0, "post_rst_add", res);
        chk("post_rst_add.spec", res, 16'h0002);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
